// File: rtl/ram_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ram_wb_buffer
// Brief    : MXU-to-RAM write-back buffer. Queues a programmed burst of rows
//            in a small FIFO and issues one RAM write per row at start +/- n.
// Options  : WB_ZERO_STRB_SKIP_EN - all-zero-strobe rows retire without a write
// Revision : 1.0 - initial release
// ============================================================================
module ram_wb_buffer #(
   parameter int ENT_NUM    = 4,
   parameter int RAM_WIDTH  = 128,
   parameter int RAM_AWIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ctrl_wb_vld,
   input  logic [RAM_AWIDTH-1:0]   ctrl_wb_start_addr,
   input  logic [3:0]              ctrl_wb_ent_num,
   input  logic                    ctrl_wb_dir,
   input  logic                    mxu_wb_vld,
   input  logic [RAM_WIDTH/8-1:0]  mxu_wb_strb,
   input  logic [RAM_WIDTH-1:0]    mxu_wb_data,
   output logic                    mxu_wb_rdy,
   output logic                    ram_write_vld,
   output logic [RAM_AWIDTH-1:0]   ram_write_addr,
   output logic [RAM_WIDTH/8-1:0]  ram_write_strb,
   output logic [RAM_WIDTH-1:0]    ram_write_data,
   input  logic                    ram_write_rdy,
   output logic                    wb_busy,
   output logic                    wb_done
);

   localparam int STRB_W = RAM_WIDTH / 8;
   localparam int PTR_W  = $clog2(ENT_NUM);
   localparam logic [RAM_AWIDTH-1:0] ADDR_ONE = RAM_AWIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 r_state;
   logic [PTR_W:0]         r_wptr;
   logic [PTR_W:0]         r_rptr;
   logic [RAM_WIDTH-1:0]   r_data [ENT_NUM];
   logic [STRB_W-1:0]      r_strb [ENT_NUM];
   logic [RAM_AWIDTH-1:0]  r_start_addr;
   logic [RAM_AWIDTH-1:0]  r_offset;
   logic [3:0]             r_ent_num;
   logic [3:0]             r_cnt;
   logic                   r_dir;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_active;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_skip;
   logic                   w_wr_vld;
   logic                   w_last_accept;
   logic [PTR_W:0]         w_wptr_nxt;
   logic [PTR_W:0]         w_rptr_nxt;
   logic                   w_empty_nxt;
   logic [STRB_W-1:0]      w_head_strb;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign w_full   = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
   assign w_empty  = (r_wptr == r_rptr);
   assign w_active = (r_state == S_RECV) || (r_state == S_DRAIN);

   assign w_head_strb = r_strb[r_rptr[PTR_W-1:0]];

`ifdef WB_ZERO_STRB_SKIP_EN
   assign w_skip   = ~w_empty & w_active & (w_head_strb == '0);
   assign w_wr_vld = ~w_empty & w_active & (w_head_strb != '0);
`else
   assign w_skip   = 1'b0;
   assign w_wr_vld = ~w_empty & w_active;
`endif

   assign mxu_wb_rdy    = (r_state == S_RECV) & ~w_full;
   assign w_push        = mxu_wb_vld & mxu_wb_rdy;
   assign w_pop         = (w_wr_vld & ram_write_rdy) | w_skip;
   assign w_last_accept = w_push & (r_cnt == r_ent_num);

   assign w_wptr_nxt  = r_wptr + (PTR_W+1)'(w_push);
   assign w_rptr_nxt  = r_rptr + (PTR_W+1)'(w_pop);
   assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);

   assign ram_write_vld  = w_wr_vld;
   assign ram_write_addr = r_start_addr + r_offset;
   assign ram_write_strb = w_head_strb;
   assign ram_write_data = r_data[r_rptr[PTR_W-1:0]];
   assign wb_busy        = (r_state != S_IDLE);
   assign wb_done        = (r_state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_start_addr <= '0;
         r_offset     <= '0;
         r_ent_num    <= '0;
         r_cnt        <= '0;
         r_dir        <= 1'b0;
         for (int i = 0; i < ENT_NUM; i++) begin
            r_data[i] <= '0;
            r_strb[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_data[r_wptr[PTR_W-1:0]] <= mxu_wb_data;
            r_strb[r_wptr[PTR_W-1:0]] <= mxu_wb_strb;
            r_cnt                     <= r_cnt + 4'd1;
         end
         r_wptr <= w_wptr_nxt;
         r_rptr <= w_rptr_nxt;
         if (w_pop) begin
            r_offset <= r_dir ? (r_offset - ADDR_ONE) : (r_offset + ADDR_ONE);
         end

         case (r_state)
            S_IDLE: begin
               // Start of burst overrides everything; push/pop are idle here.
               if (ctrl_wb_vld) begin
                  r_start_addr <= ctrl_wb_start_addr;
                  r_ent_num    <= ctrl_wb_ent_num;
                  r_dir        <= ctrl_wb_dir;
                  r_cnt        <= '0;
                  r_offset     <= '0;
                  r_wptr       <= '0;
                  r_rptr       <= '0;
                  r_state      <= S_RECV;
               end
            end
            S_RECV: begin
               if (w_last_accept) begin
                  r_state <= w_empty_nxt ? S_DONE : S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_pop && w_empty_nxt) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_wb_buffer
// Brief    : Directed self-checking bench for ram_wb_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_wb_buffer;

   localparam int ENT_NUM = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ctrl_wb_vld;
   logic [7:0]    ctrl_wb_start_addr;
   logic [3:0]    ctrl_wb_ent_num;
   logic          ctrl_wb_dir;
   logic          mxu_wb_vld;
   logic [15:0]   mxu_wb_strb;
   logic [127:0]  mxu_wb_data;
   logic          mxu_wb_rdy;
   logic          ram_write_vld;
   logic [7:0]    ram_write_addr;
   logic [15:0]   ram_write_strb;
   logic [127:0]  ram_write_data;
   logic          ram_write_rdy;
   logic          wb_busy;
   logic          wb_done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [127:0] src_data [$];
   logic [15:0]  src_strb [$];
   int           src_idx;
   logic [7:0]   exp_addr [$];
   logic [15:0]  exp_strb [$];
   logic [127:0] exp_data [$];

   ram_wb_buffer #(.ENT_NUM(ENT_NUM), .RAM_WIDTH(128), .RAM_AWIDTH(8)) u_dut (
      .clk                (clk),
      .rst                (rst),
      .ctrl_wb_vld        (ctrl_wb_vld),
      .ctrl_wb_start_addr (ctrl_wb_start_addr),
      .ctrl_wb_ent_num    (ctrl_wb_ent_num),
      .ctrl_wb_dir        (ctrl_wb_dir),
      .mxu_wb_vld         (mxu_wb_vld),
      .mxu_wb_strb        (mxu_wb_strb),
      .mxu_wb_data        (mxu_wb_data),
      .mxu_wb_rdy         (mxu_wb_rdy),
      .ram_write_vld      (ram_write_vld),
      .ram_write_addr     (ram_write_addr),
      .ram_write_strb     (ram_write_strb),
      .ram_write_data     (ram_write_data),
      .ram_write_rdy      (ram_write_rdy),
      .wb_busy            (wb_busy),
      .wb_done            (wb_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic new_test();
      src_data.delete();
      src_strb.delete();
      exp_addr.delete();
      exp_strb.delete();
      exp_data.delete();
      src_idx = 0;
   endtask

   // Row k carries a recognisable pattern; wr=0 means no RAM write is expected.
   task automatic add_row(input logic [31:0] k, input logic [15:0] strb,
                          input logic [7:0] addr, input bit wr);
      logic [127:0] d;
      d = {k, ~k, k ^ 32'h5A5A_5A5A, 32'hC0DE_0000 + k};
      src_data.push_back(d);
      src_strb.push_back(strb);
      if (wr) begin
         exp_addr.push_back(addr);
         exp_strb.push_back(strb);
         exp_data.push_back(d);
      end
   endtask

   task automatic start_burst(input logic [7:0] start, input logic [3:0] num, input logic dir);
      chk("idle_busy", wb_busy, 1'b0);
      ctrl_wb_vld        = 1'b1;
      ctrl_wb_start_addr = start;
      ctrl_wb_ent_num    = num;
      ctrl_wb_dir        = dir;
      @(negedge clk);
      ctrl_wb_vld = 1'b0;
      chk("start_busy", wb_busy, 1'b1);
   endtask

   // One iteration per cycle: drive at negedge, settle, score handshakes.
   task automatic run_burst(input int stall, input int inject, input int limit);
      int cyc;
      cyc = 0;
      while ((exp_addr.size() > 0 || src_idx < src_data.size()) && cyc < limit) begin
         mxu_wb_vld = (src_idx < src_data.size());
         if (src_idx < src_data.size()) begin
            mxu_wb_data = src_data[src_idx];
            mxu_wb_strb = src_strb[src_idx];
         end else begin
            mxu_wb_data = '0;
            mxu_wb_strb = '0;
         end
         ram_write_rdy = (cyc >= stall);
         ctrl_wb_vld   = (cyc == inject);
         if (cyc == inject) begin
            ctrl_wb_start_addr = 8'h80;
            ctrl_wb_ent_num    = 4'd0;
            ctrl_wb_dir        = 1'b1;
         end
         #1;
         if (cyc == 0) chk("no_bypass", ram_write_vld, 1'b0);
         if (stall > 0 && cyc == stall - 1) begin
            chk("full_taken", src_idx, ENT_NUM);
            chk("full_rdy", mxu_wb_rdy, 1'b0);
         end
         if (cyc < stall && ram_write_vld && exp_addr.size() > 0) begin
            chk("stall_addr", ram_write_addr, exp_addr[0]);
            chk("stall_data", ram_write_data, exp_data[0]);
         end
         if (ram_write_vld && ram_write_rdy) begin
            if (exp_addr.size() == 0) begin
               chk("extra_write", 1'b1, 1'b0);
            end else begin
               chk("wr_addr", ram_write_addr, exp_addr.pop_front());
               chk("wr_strb", ram_write_strb, exp_strb.pop_front());
               chk("wr_data", ram_write_data, exp_data.pop_front());
            end
         end
         if (mxu_wb_vld && mxu_wb_rdy) src_idx++;
         @(negedge clk);
         cyc++;
      end
      chk("burst_complete", exp_addr.size(), 0);
      ctrl_wb_vld   = 1'b0;
      mxu_wb_vld    = 1'b0;
      ram_write_rdy = 1'b1;
   endtask

   task automatic finish_burst();
      chk("done_pulse", wb_done, 1'b1);
      chk("done_busy", wb_busy, 1'b1);
      @(negedge clk);
      chk("done_clear", wb_done, 1'b0);
      chk("busy_clear", wb_busy, 1'b0);
   endtask

   initial begin
      rst                = 1'b1;
      ctrl_wb_vld        = 1'b0;
      ctrl_wb_start_addr = '0;
      ctrl_wb_ent_num    = '0;
      ctrl_wb_dir        = 1'b0;
      mxu_wb_vld         = 1'b0;
      mxu_wb_strb        = '0;
      mxu_wb_data        = '0;
      ram_write_rdy      = 1'b1;
      src_idx            = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_vld", ram_write_vld, 1'b0);
      chk("rst_addr", ram_write_addr, 8'h00);
      chk("rst_data", ram_write_data, 128'h0);
      chk("rst_rdy", mxu_wb_rdy, 1'b0);
      chk("rst_done", wb_done, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Incrementing burst of four rows
      new_test();
      add_row(32'h1, 16'hFFFF, 8'h10, 1'b1);
      add_row(32'h2, 16'h00F0, 8'h11, 1'b1);
      add_row(32'h3, 16'h8001, 8'h12, 1'b1);
      add_row(32'h4, 16'h0F0F, 8'h13, 1'b1);
      start_burst(8'h10, 4'd3, 1'b0);
      run_burst(0, -1, 200);
      finish_burst();

      // Decrementing burst wrapping through 0x00
      new_test();
      add_row(32'h11, 16'hFFFF, 8'h01, 1'b1);
      add_row(32'h12, 16'h0001, 8'h00, 1'b1);
      add_row(32'h13, 16'h1234, 8'hFF, 1'b1);
      add_row(32'h14, 16'hFF00, 8'hFE, 1'b1);
      start_burst(8'h01, 4'd3, 1'b1);
      run_burst(0, -1, 200);
      finish_burst();

      // RAM back-pressure for 10 cycles during a 16-row stream
      new_test();
      for (int i = 0; i < 16; i++) begin
         add_row(32'h100 + 32'(i), 16'(i * 37 + 1), 8'h20 + 8'(i), 1'b1);
      end
      start_burst(8'h20, 4'd15, 1'b0);
      run_burst(10, -1, 400);
      finish_burst();

      // Start request mid-burst must be ignored
      new_test();
      add_row(32'h21, 16'hFFFF, 8'h30, 1'b1);
      add_row(32'h22, 16'hAAAA, 8'h31, 1'b1);
      add_row(32'h23, 16'h5555, 8'h32, 1'b1);
      add_row(32'h24, 16'h0003, 8'h33, 1'b1);
      start_burst(8'h30, 4'd3, 1'b0);
      run_burst(0, 2, 200);
      finish_burst();

      // Reset mid-burst, then a one-row burst with no stale writes
      new_test();
      add_row(32'h31, 16'hFFFF, 8'h60, 1'b0);
      add_row(32'h32, 16'hFFFF, 8'h61, 1'b0);
      start_burst(8'h60, 4'd7, 1'b0);
      run_burst(1000, -1, 100);
      chk("pre_rst_vld", ram_write_vld, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_vld", ram_write_vld, 1'b0);
      chk("mid_rst_addr", ram_write_addr, 8'h00);
      chk("mid_rst_strb", ram_write_strb, 16'h0);
      chk("mid_rst_data", ram_write_data, 128'h0);
      chk("mid_rst_busy", wb_busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      new_test();
      add_row(32'h41, 16'hC3C3, 8'h40, 1'b1);
      start_burst(8'h40, 4'd0, 1'b0);
      run_burst(0, -1, 100);
      finish_burst();
      for (int i = 0; i < 3; i++) begin
         chk("post_idle_vld", ram_write_vld, 1'b0);
         @(negedge clk);
      end

      // Zero-strobe row in the middle of a burst
      new_test();
      add_row(32'h51, 16'hFFFF, 8'h50, 1'b1);
      add_row(32'h52, 16'h00FF, 8'h51, 1'b1);
`ifdef WB_ZERO_STRB_SKIP_EN
      add_row(32'h53, 16'h0000, 8'h52, 1'b0);
`else
      add_row(32'h53, 16'h0000, 8'h52, 1'b1);
`endif
      add_row(32'h54, 16'hF000, 8'h53, 1'b1);
      start_burst(8'h50, 4'd3, 1'b0);
      run_burst(0, -1, 200);
      finish_burst();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
